// File: rtl/spi_slave_rx.sv
// spi_slave_rx - SPI mode 0 slave receiver, MSB first.
//
// The SPI pad inputs are oversampled in the clk domain. Each received byte
// is presented on a valid/ready handshake. A frame may carry several bytes.
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   SPI_sclk      serial clock from the master (idles low)
//   SPI_csn       chip select (active low)
//   SPI_mosi      serial data from the master
//   SPI_miso      serial data to the master
//   rx_data       received byte; stable while rx_valid is high
//   rx_valid      a byte is pending; held until rx_ready accepts it
//   rx_ready      consumer accepts the pending byte
//   rx_overrun    1-cycle pulse: a byte completed while the previous one was
//                 still pending, so the new byte was dropped
//   rx_frame_err  1-cycle pulse: CSN rose with 1-7 bits of a byte received
//   tx_data       byte to return on SPI_miso; sampled at CSN fall and at each
//                 byte boundary
//
// Parameter SYNC_STAGES (2 or 3) sets the synchroniser depth.
// Define SPI_SLAVE_RX_MISO_EN to enable the full-duplex return path.
// Without it, SPI_miso is tied low and tx_data is ignored.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_sclk,
  input  logic       SPI_csn,
  input  logic       SPI_mosi,
  output logic       SPI_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   csn_hist_q, csn_hist_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_overrun_q, rx_overrun_d;
  logic                   rx_frame_err_q, rx_frame_err_d;

  logic sclk_s, csn_s, mosi_s;
  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [7:0] byte_done;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign csn_rise  = csn_s & ~csn_hist_q;
  assign csn_fall  = ~csn_s & csn_hist_q;
  assign byte_done = {rx_shift_q[6:0], mosi_s};

`ifdef SPI_SLAVE_RX_MISO_EN
  logic [7:0] tx_shift_q, tx_shift_d;
`else
  logic unused_tx;
  assign unused_tx = ^tx_data;
`endif

  always_comb begin
    sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], SPI_sclk};
    csn_sync_d     = {csn_sync_q[SYNC_STAGES-2:0], SPI_csn};
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], SPI_mosi};
    sclk_hist_d    = sclk_s;
    csn_hist_d     = csn_s;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q & ~rx_ready;
    rx_overrun_d   = 1'b0;
    rx_frame_err_d = 1'b0;
`ifdef SPI_SLAVE_RX_MISO_EN
    tx_shift_d     = tx_shift_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (csn_fall) begin
          state_d = ST_SHIFT;
`ifdef SPI_SLAVE_RX_MISO_EN
          tx_shift_d = tx_data;
`endif
        end
      end
      ST_SHIFT: begin
        // If CSN rises in the same cycle as an SCLK edge, the CSN rise is
        // handled and the SCLK edge is dropped.
        if (csn_rise) begin
          state_d        = ST_IDLE;
          rx_frame_err_d = (bit_cnt_q != 3'd0);
          bit_cnt_d      = '0;
          rx_shift_d     = '0;
        end else if (sclk_rise) begin
          rx_shift_d = byte_done;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = byte_done;
              rx_valid_d = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
`ifdef SPI_SLAVE_RX_MISO_EN
            tx_shift_d = tx_data;
`endif
          end
        end
`ifdef SPI_SLAVE_RX_MISO_EN
        // The falling edge that follows a byte boundary must not shift.
        // Bit 7 of the newly loaded byte has to stay on MISO until the
        // next rising edge.
        else if (sclk_fall && bit_cnt_q != 3'd0) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q    <= '0;
      csn_sync_q     <= '1;
      mosi_sync_q    <= '0;
      sclk_hist_q    <= 1'b0;
      csn_hist_q     <= 1'b1;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef SPI_SLAVE_RX_MISO_EN
      tx_shift_q     <= '0;
`endif
    end else begin
      sclk_sync_q    <= sclk_sync_d;
      csn_sync_q     <= csn_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      sclk_hist_q    <= sclk_hist_d;
      csn_hist_q     <= csn_hist_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
`ifdef SPI_SLAVE_RX_MISO_EN
      tx_shift_q     <= tx_shift_d;
`endif
    end
  end

`ifdef SPI_SLAVE_RX_MISO_EN
  assign SPI_miso = ~csn_s & tx_shift_q[7];
`else
  assign SPI_miso = 1'b0;
`endif

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI slave receiver: the far end of the team's SPI master transmitter. Oversamples SPI_sclk, SPI_csn and SPI_mosi in the system clock domain, deserialises MSB-first bytes (SPI mode 0) and presents each byte on a valid/ready handshake. Optionally returns a byte on SPI_miso in full duplex. Sits between the SPI pads and the register/command decoder of the peripheral side.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on SPI inputs (legal: 2 or 3).

Ports:
- clk  input  1  system clock; sole clock.
- rst  input  1  reset, synchronous, active-high.
- SPI_sclk  input  1  serial clock from master, idle low.
- SPI_csn  input  1  chip select, active low.
- SPI_mosi  input  1  serial data from master.
- SPI_miso  output  1  serial data to master.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready.
- rx_overrun  output  1  one-cycle pulse: byte completed while rx_valid still pending.
- rx_frame_err  output  1  one-cycle pulse: CSN rose with 1-7 bits received.
- tx_data  input  8  byte returned on SPI_miso; sampled at CSN fall and at each byte boundary.

## Operation
- All SPI inputs pass through SYNC_STAGES flops plus one history flop; edges detected from last sync stage vs history. SPI_csn synchroniser resets to 1, SPI_sclk/SPI_mosi to 0.
- FSM: IDLE, SHIFT.
  - IDLE: bit_cnt=0. Synced CSN fall -> SHIFT; load tx shift register from tx_data.
  - SHIFT: each synced SCLK rising edge shifts synced MOSI into rx_shift LSB (MSB-first), bit_cnt+1 (3-bit, wraps 7->0).
  - On the rising edge that completes bit 8: if rx_valid=0 or (rx_valid & rx_ready) same cycle, rx_data<=completed byte, rx_valid<=1; else byte dropped, rx_data unchanged, rx_overrun pulses. tx shift register reloads from tx_data. Stay in SHIFT (multi-byte frames).
  - Synced CSN rise -> IDLE; if bit_cnt!=0, rx_frame_err pulses, partial bits discarded.
- rx_valid clears on rx_valid & rx_ready unless a new byte is captured that cycle (then stays 1 with new data).
- CSN rise and SCLK rise in the same cycle: CSN wins; the edge is ignored.
- SCLK edges while in IDLE are ignored.
- Reset mid-frame: FSM->IDLE, bit_cnt=0, shift registers cleared; next capture requires a fresh CSN fall.

## Timing
- Reset values: SPI_miso=0, rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0.
- Latency: raw SCLK rise of bit 8 -> rx_valid high after SYNC_STAGES+1 clk edges (3 for default).
- Constraint: SCLK high and low time each >= SYNC_STAGES+1 clk cycles; with the team's master on the same clk this means sclk_divider >= 2.
- CSN setup to first SCLK rise >= SYNC_STAGES+1 clk cycles.
- rx_overrun and rx_frame_err are exactly one cycle wide; never asserted simultaneously for the same event.

## Configuration
- SPI_SLAVE_RX_MISO_EN defined: SPI_miso = tx shift register bit 7 while synced CSN low, else 0; register shifts left on each synced SCLK falling edge; first bit valid before first SCLK rise.
- Not defined: SPI_miso tied 0, tx_data ignored, no tx shift register instantiated.

## Test plan
- Single frame, CSN low, bytes 0xA5 MSB-first, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5, no error pulses.
- Three-byte frame 0x01,0x80,0xFF with rx_ready=0 until end -> first byte 0x01 held, rx_overrun pulses twice, rx_data stays 0x01 after frame.
- CSN rises after 5 bits -> rx_frame_err one cycle, rx_valid stays 0; next frame 0x3C received correctly.
- Reset asserted after 4 bits, released, frame 0x5A sent -> rx_data=0x5A, no frame error.
- With SPI_SLAVE_RX_MISO_EN, tx_data=0xC3, master sends 0x00 -> master samples 0xC3 on MISO on SCLK rises; without macro MISO constant 0.
- Loopback with team master at sclk_divider=2 sending 0x96 -> rx_data=0x96, rx_valid within 3 clk of final SCLK rise.
